counter_x3: RTL and testbench



---
 rtl/counter_x3_pkg.sv | 18 +
 rtl/counter_x3_if.sv | 22 ++
 rtl/counter_x3_chan.sv | 96 +++++++++
 rtl/counter_x3.sv | 85 ++++++++
 tb/tb_counter_x3.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/counter_x3_pkg.sv
// Shared constants and types for the three-channel down-counter peripheral.
package counter_x3_pkg;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RATE    = 2'b01;
   localparam logic [1:0] MODE_SQUARE  = 2'b10;
   localparam logic [1:0] MODE_STOP    = 2'b11;

   localparam logic [1:0] CH_CTRL = 2'd3;
   localparam int         NUM_CH  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chan_state_e;

endpackage

// File: rtl/counter_x3_if.sv
// Decoder-side bus of counter_x3: target select, write strobe/data, read data and terminal outputs.
interface counter_x3_if #(
   parameter int CNT_W = 32
);
   logic [1:0]       counter_ch;
   logic             counter_we;
   logic [CNT_W-1:0] counter_val;
   logic [CNT_W-1:0] counter_out;
   logic             counter0_out;
   logic             counter1_out;
   logic             counter2_out;

   modport master (
      output counter_ch, counter_we, counter_val,
      input  counter_out, counter0_out, counter1_out, counter2_out
   );

   modport slave (
      input  counter_ch, counter_we, counter_val,
      output counter_out, counter0_out, counter1_out, counter2_out
   );
endinterface

// File: rtl/counter_x3_chan.sv
// One down-counter channel: load/cnt registers, terminal output bit and IDLE/RUN/DONE state.
module counter_x3_chan
   import counter_x3_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_val_i,
   input  logic             tick_i,
   input  logic [1:0]       mode_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             out_o,
   output logic             tc_o
);

   chan_state_e      state_q, state_d;
   logic [CNT_W-1:0] load_q, load_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             tc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         load_q  <= '0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      tc      = 1'b0;
      if (wr_i) begin
         // A write always beats a coincident tick.
         load_d = wr_val_i;
         cnt_d  = wr_val_i;
         out_d  = 1'b0;
         if (mode_i == MODE_STOP)
            state_d = IDLE;
         else if (wr_val_i == '0 && mode_i != MODE_ONESHOT)
            state_d = IDLE;
         else
            state_d = RUN;
      end else if (state_q == RUN) begin
         if (mode_i == MODE_RATE) out_d = 1'b0;
         if (cnt_q == '0) begin
            // Zero load: one-shot expires on the next clock, periodic modes park.
            if (mode_i == MODE_ONESHOT) begin
               out_d   = 1'b1;
               state_d = DONE;
               tc      = 1'b1;
            end else if (mode_i != MODE_STOP) begin
               out_d   = 1'b0;
               state_d = IDLE;
            end
         end else if (tick_i && mode_i != MODE_STOP) begin
            if (cnt_q == CNT_W'(1)) begin
               tc = 1'b1;
               case (mode_i)
                  MODE_ONESHOT: begin
                     cnt_d   = '0;
                     out_d   = 1'b1;
                     state_d = DONE;
                  end
                  MODE_RATE: begin
                     cnt_d = load_q;
                     out_d = 1'b1;
                  end
                  default: begin
                     cnt_d = load_q;
                     out_d = ~out_q;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      end
   end

   assign cnt_o = cnt_q;
   assign out_o = out_q;
   assign tc_o  = tc;

endmodule

// File: rtl/counter_x3.sv
// Three-channel programmable down-counter: control word, write decode, read mux.
// Optional COUNTER_X3_IRQ_EN adds sticky terminal-count flags and an irq output.
module counter_x3
   import counter_x3_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick,
   counter_x3_if.slave  bus
`ifdef COUNTER_X3_IRQ_EN
   ,
   output logic         irq
`endif
);

   logic [5:0]                   mode_q, mode_d;
   logic                         ctrl_wr;
   logic [NUM_CH-1:0]            chan_wr;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt;
   logic [NUM_CH-1:0]            tc_out;
   logic [NUM_CH-1:0]            tc_evt;
   logic [2:0]                   flags_rd;

   assign ctrl_wr = bus.counter_we && (bus.counter_ch == CH_CTRL);
   assign mode_d  = ctrl_wr ? bus.counter_val[5:0] : mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_q <= 6'h3F;
      else        mode_q <= mode_d;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      assign chan_wr[g] = bus.counter_we && (bus.counter_ch == 2'(g));

      counter_x3_chan #(.CNT_W(CNT_W)) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_i     (chan_wr[g]),
         .wr_val_i (bus.counter_val),
         .tick_i   (tick),
         .mode_i   (mode_q[2*g +: 2]),
         .cnt_o    (cnt[g]),
         .out_o    (tc_out[g]),
         .tc_o     (tc_evt[g])
      );
   end

`ifdef COUNTER_X3_IRQ_EN
   logic [2:0] tc_flag_q, tc_flag_d;
   logic [2:0] flag_clr;

   assign flag_clr  = ctrl_wr ? bus.counter_val[10:8] : 3'b000;
   // Set has priority over a same-cycle clear.
   assign tc_flag_d = (tc_flag_q & ~flag_clr) | tc_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tc_flag_q <= 3'b000;
      else        tc_flag_q <= tc_flag_d;
   end

   assign irq      = |tc_flag_q;
   assign flags_rd = tc_flag_q;
`else
   logic unused_tc;
   assign unused_tc = ^tc_evt;
   assign flags_rd  = 3'b000;
`endif

   always_comb begin
      bus.counter_out = '0;
      case (bus.counter_ch)
         2'd0:    bus.counter_out = cnt[0];
         2'd1:    bus.counter_out = cnt[1];
         2'd2:    bus.counter_out = cnt[2];
         default: bus.counter_out = CNT_W'({flags_rd, 2'b00, mode_q});
      endcase
   end

   assign bus.counter0_out = tc_out[0];
   assign bus.counter1_out = tc_out[1];
   assign bus.counter2_out = tc_out[2];

endmodule

// File: tb/tb_counter_x3.sv
// Directed bench for counter_x3: vector table plus hand sequences for reset and irq corners.
module tb_counter_x3;

   logic clk;
   logic rst_n;
   logic tick;
`ifdef COUNTER_X3_IRQ_EN
   logic irq;
`endif

   counter_x3_if #(.CNT_W(32)) bus ();

   counter_x3 #(.CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .bus   (bus)
`ifdef COUNTER_X3_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  ch;
      logic [31:0] val;
      logic        tk;
      logic [1:0]  rd;
      logic [31:0] exp_out;
      logic [2:0]  exp_tc;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   function automatic void v(input logic we, input logic [1:0] ch, input logic [31:0] val,
                             input logic tk, input logic [1:0] rd, input logic [31:0] eo,
                             input logic [2:0] et);
      vec_t r;
      r.we = we; r.ch = ch; r.val = val; r.tk = tk; r.rd = rd; r.exp_out = eo; r.exp_tc = et;
      vecs.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] tc_now();
      return {29'd0, bus.counter2_out, bus.counter1_out, bus.counter0_out};
   endfunction

   // Drive one bus cycle, then leave counter_ch on the read select.
   task automatic cyc(input logic we, input logic [1:0] ch, input logic [31:0] val,
                      input logic tk, input logic [1:0] rd);
      @(negedge clk);
      bus.counter_we = we; bus.counter_ch = ch; bus.counter_val = val; tick = tk;
      @(posedge clk);
      #1;
      bus.counter_we = 1'b0; tick = 1'b0; bus.counter_ch = rd;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0;
      bus.counter_we = 1'b0; bus.counter_ch = 2'd0; bus.counter_val = '0;
      #2;
      for (int c = 0; c < 4; c++) begin
         bus.counter_ch = 2'(c);
         #1;
         chk($sformatf("reset_rd_ch%0d", c), bus.counter_out, (c == 3) ? 32'h3F : 32'h0);
      end
      chk("reset_tc", tc_now(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // one-shot ch0, load 5
      v(1,3,32'h00,0,3,32'h00,3'b000);
      v(1,0,32'd5,0,0,32'd5,3'b000);
      v(0,0,0,1,0,32'd4,3'b000);
      v(0,0,0,1,0,32'd3,3'b000);
      v(0,0,0,1,0,32'd2,3'b000);
      v(0,0,0,1,0,32'd1,3'b000);
      v(0,0,0,1,0,32'd0,3'b001);
      v(0,0,0,1,0,32'd0,3'b001);
      // rate ch1, load 3: pulses at ticks 3, 6, 9
      v(1,3,32'h04,0,3,32'h04,3'b001);
      v(1,1,32'd3,0,1,32'd3,3'b001);
      v(0,0,0,1,1,32'd2,3'b001);
      v(0,0,0,1,1,32'd1,3'b001);
      v(0,0,0,1,1,32'd3,3'b011);
      v(0,0,0,0,1,32'd3,3'b001);
      v(0,0,0,1,1,32'd2,3'b001);
      v(0,0,0,1,1,32'd1,3'b001);
      v(0,0,0,1,1,32'd3,3'b011);
      v(0,0,0,1,1,32'd2,3'b001);
      v(0,0,0,1,1,32'd1,3'b001);
      v(0,0,0,1,1,32'd3,3'b011);
      v(0,0,0,0,1,32'd3,3'b001);
      // square ch2, load 2, ch1 stopped: toggles at ticks 2, 4, 6, 8
      v(1,3,32'h2C,0,3,32'h2C,3'b001);
      v(1,2,32'd2,0,2,32'd2,3'b001);
      v(0,0,0,1,2,32'd1,3'b001);
      v(0,0,0,1,2,32'd2,3'b101);
      v(0,0,0,1,2,32'd1,3'b101);
      v(0,0,0,1,2,32'd2,3'b001);
      v(0,0,0,1,2,32'd1,3'b001);
      v(0,0,0,1,2,32'd2,3'b101);
      v(0,0,0,1,2,32'd1,3'b101);
      v(0,0,0,1,2,32'd2,3'b001);
      v(0,0,0,0,1,32'd3,3'b001);
      // ch1 resumes from the held count
      v(1,3,32'h24,0,3,32'h24,3'b001);
      v(0,0,0,1,1,32'd2,3'b001);
      // write of 10 coincides with tick 2 on ch0
      v(1,3,32'h3C,0,3,32'h3C,3'b001);
      v(1,0,32'd4,0,0,32'd4,3'b000);
      v(0,0,0,1,0,32'd3,3'b000);
      v(1,0,32'd10,1,0,32'd10,3'b000);
      for (int k = 9; k >= 1; k--) v(0,0,0,1,0,32'(k),3'b000);
      v(0,0,0,1,0,32'd0,3'b001);
      // load 0: one-shot expires next clock, rate parks idle without wrapping
      v(1,0,32'd0,0,0,32'd0,3'b000);
      v(0,0,0,0,0,32'd0,3'b001);
      v(1,3,32'h3D,0,3,32'h3D,3'b001);
      v(1,0,32'd0,0,0,32'd0,3'b000);
      v(0,0,0,1,0,32'd0,3'b000);
      v(0,0,0,1,0,32'd0,3'b000);
      // write under stop mode loads but does not count
      v(1,3,32'h3F,0,3,32'h3F,3'b000);
      v(1,0,32'd7,0,0,32'd7,3'b000);
      v(0,0,0,1,0,32'd7,3'b000);

      foreach (vecs[i]) begin
         cyc(vecs[i].we, vecs[i].ch, vecs[i].val, vecs[i].tk, vecs[i].rd);
         chk($sformatf("vec%0d_out", i), bus.counter_out, vecs[i].exp_out);
         chk($sformatf("vec%0d_tc", i), tc_now(), {29'd0, vecs[i].exp_tc});
      end

      // asynchronous reset in the middle of a count
      cyc(1, 3, 32'h3E, 0, 3);
      cyc(1, 0, 32'd5, 0, 0);
      cyc(0, 0, 0, 1, 0);
      chk("pre_rst_cnt", bus.counter_out, 32'd4);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", bus.counter_out, 32'd0);
      bus.counter_ch = 2'd3;
      #1;
      chk("async_rst_ctrl", bus.counter_out, 32'h3F);
      bus.counter_ch = 2'd1;
      #1;
      chk("async_rst_ch1", bus.counter_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef COUNTER_X3_IRQ_EN
      chk("irq_reset", 32'(irq), 32'd0);
      cyc(1, 3, 32'h37, 0, 3);
      cyc(1, 1, 32'd1, 0, 3);
      cyc(0, 0, 0, 1, 3);
      chk("irq_set", 32'(irq), 32'd1);
      chk("flag_rd", bus.counter_out, 32'h237);
      cyc(1, 3, 32'h237, 0, 3);
      chk("irq_clr", 32'(irq), 32'd0);
      chk("flag_rd_clr", bus.counter_out, 32'h37);
      cyc(0, 0, 0, 1, 3);
      chk("irq_set2", 32'(irq), 32'd1);
      cyc(1, 3, 32'h237, 1, 3);
      chk("irq_set_wins", 32'(irq), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
